// File: rtl/mem_island_bank_arbiter.sv
// Per-bank arbiter: port 0 has priority, narrow ports share round-robin with a starvation guard.
// Responses are routed back to the originating port through a BankLatency-deep {valid, id} pipe.
module mem_island_bank_arbiter #(
    parameter int unsigned NumReq      = 4,
    parameter int unsigned AddrWidth   = 10,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned BankLatency = 1,
    parameter int unsigned MaxWait     = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_i,
    output logic [NumReq-1:0]               gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq-1:0]               we_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*(DataWidth/8)-1:0] strb_i,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [NumReq*DataWidth-1:0]     rdata_o,
    output logic                            bank_req_o,
    output logic [AddrWidth-1:0]            bank_addr_o,
    output logic                            bank_we_o,
    output logic [DataWidth-1:0]            bank_wdata_o,
    output logic [DataWidth/8-1:0]          bank_strb_o,
    input  logic [DataWidth-1:0]            bank_rdata_i
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdWidth-1:0] win_id;

    if (BankLatency < 1) begin : gen_bad_latency
        $error("BankLatency must be at least 1");
    end
    if (DataWidth % 8 != 0) begin : gen_bad_width
        $error("DataWidth must be a multiple of 8");
    end

    if (NumReq == 1) begin : gen_single
        assign gnt_o  = req_i;
        assign win_id = '0;
    end else begin : gen_multi
        localparam int unsigned WaitWidth = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
        localparam logic [WaitWidth-1:0] WaitMax = WaitWidth'(MaxWait);
        localparam logic [IdWidth-1:0]   LastId  = IdWidth'(NumReq - 1);
        localparam logic [IdWidth-1:0]   FirstId = IdWidth'(1);

        logic [WaitWidth-1:0] wait_q, wait_d;
        logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;
        logic [IdWidth-1:0]   idx;
        logic                 narrow_req, narrow_gnt, force_narrow, found;

        assign narrow_req   = |req_i[NumReq-1:1];
        assign narrow_gnt   = |gnt_o[NumReq-1:1];
        assign force_narrow = (MaxWait > 0) && (wait_q == WaitMax) && narrow_req;

        always_comb begin
            gnt_o  = '0;
            win_id = '0;
            found  = 1'b0;
            idx    = '0;
            if (req_i[0] && !force_narrow) begin
                gnt_o[0] = 1'b1;
            end else begin
                // Circular scan over ports 1..NumReq-1 starting at rr_ptr_q.
                for (int unsigned i = 0; i < NumReq - 1; i++) begin
                    idx = IdWidth'((32'(rr_ptr_q) - 1 + i) % (NumReq - 1) + 1);
                    if (!found && req_i[idx]) begin
                        found      = 1'b1;
                        gnt_o[idx] = 1'b1;
                        win_id     = idx;
                    end
                end
            end
        end

        always_comb begin
            wait_d   = wait_q;
            rr_ptr_d = rr_ptr_q;
            if (narrow_gnt || !narrow_req) begin
                wait_d = '0;
            end else if (gnt_o[0] && (wait_q != WaitMax)) begin
                wait_d = wait_q + 1'b1;
            end
            if (narrow_gnt) begin
                rr_ptr_d = (win_id == LastId) ? FirstId : win_id + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wait_q   <= '0;
                rr_ptr_q <= FirstId;
            end else begin
                wait_q   <= wait_d;
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    assign bank_req_o = |gnt_o;

    always_comb begin
        bank_addr_o  = '0;
        bank_we_o    = 1'b0;
        bank_wdata_o = '0;
        bank_strb_o  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (gnt_o[k]) begin
                bank_addr_o  = addr_i[k*AddrWidth +: AddrWidth];
                bank_we_o    = we_i[k];
                bank_wdata_o = wdata_i[k*DataWidth +: DataWidth];
                bank_strb_o  = strb_i[k*StrbWidth +: StrbWidth];
            end
        end
    end

    logic [BankLatency-1:0] vld_q;
    logic [IdWidth-1:0]     id_q [BankLatency];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int unsigned s = 0; s < BankLatency; s++) begin
                id_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= bank_req_o;
            id_q[0]  <= win_id;
            for (int unsigned s = 1; s < BankLatency; s++) begin
                vld_q[s] <= vld_q[s-1];
                id_q[s]  <= id_q[s-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (vld_q[BankLatency-1] && (32'(id_q[BankLatency-1]) == k)) begin
                rvalid_o[k]                       = 1'b1;
                rdata_o[k*DataWidth +: DataWidth] = bank_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(gnt_o));
        end
    end

endmodule

// File: doc/mem_island_bank_arbiter.md
Name: mem_island_bank_arbiter

Overview:
Per-bank arbiter for the next-generation memory island. It serves NumReq req/gnt memory ports contending for one SRAM bank. Port 0 is the priority (wide-slice) port. Ports 1..NumReq-1 (narrow) share round-robin arbitration. A configurable starvation counter forces a narrow grant after MaxWait consecutive priority wins. The block also tracks in-flight accesses through a BankLatency-deep pipeline and routes each bank response back to its originating port.

Parameters:
NumReq, 4, number of requestor ports (>=1); port 0 is priority
AddrWidth, 10, bank-local word address width
DataWidth, 32, data width; StrbWidth = DataWidth/8
BankLatency, 1, cycles from bank_req_o to valid bank_rdata_i (>=1)
MaxWait, 0, consecutive port-0 wins tolerated while a narrow request is pending; 0 = port 0 always wins

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_i  in  NumReq  request per port
gnt_o  out  NumReq  grant per port, same cycle as accepted req
addr_i  in  NumReq*AddrWidth  word address per port
we_i  in  NumReq  write enable per port
wdata_i  in  NumReq*DataWidth  write data per port
strb_i  in  NumReq*StrbWidth  byte strobes per port
rvalid_o  out  NumReq  response valid (for both reads and writes)
rdata_o  out  NumReq*DataWidth  read data per port
bank_req_o  out  1  bank access
bank_addr_o  out  AddrWidth  bank address
bank_we_o  out  1  bank write enable
bank_wdata_o  out  DataWidth  bank write data
bank_strb_o  out  StrbWidth  bank byte strobes
bank_rdata_i  in  DataWidth  bank read data, valid BankLatency cycles after access

Behaviour:
- Arbitration is combinational in cycle t. At most one gnt_o bit is set.
  - gnt_o[k] = 1 implies req_i[k] = 1.
  - bank_req_o = |gnt_o.
  - bank_addr/we/wdata/strb mux from the granted port; all zero when no grant.
- Winner selection:
  - If req_i[0] and not force_narrow: grant port 0.
  - Otherwise grant the first requesting port in 1..NumReq-1, searching circularly from rr_ptr_q.
- force_narrow = (MaxWait>0) && (wait_q == MaxWait) && (|req_i[NumReq-1:1]).
- wait_q (width clog2(MaxWait+1)):
  - increments when port 0 is granted while any narrow request is pending;
  - clears when any narrow port is granted, or when no narrow request is pending;
  - saturates at MaxWait and never wraps.
- rr_ptr_q:
  - on a narrow grant to port k, becomes k+1;
  - wraps from NumReq-1 back to 1;
  - is unchanged otherwise.
- Response pipeline: BankLatency stages of {valid, port id}.
  - Stage 0 loads {bank_req_o, winner id} every cycle.
  - rvalid_o[id] = last-stage valid for the matching id.
  - rdata_o[id] = bank_rdata_i when rvalid_o[id], else '0.
  - Throughput is one access per cycle. Back-to-back grants produce back-to-back rvalids in grant order.
- Simultaneous events: a grant in cycle t and an rvalid from an older access in cycle t are independent. A port may receive gnt and rvalid in the same cycle.
- NumReq==1: pure passthrough with gnt_o = req_i. No counter or rr logic is generated.
- Reset values:
  - gnt_o follows req_i combinationally (not forced).
  - rvalid_o = 0, rdata_o = 0.
  - wait_q = 0, rr_ptr_q = 1, all pipeline valids = 0.
- Reset mid-operation: all in-flight responses are dropped (no rvalid issued for them). Requestors are reset in the same domain.
- Assertions:
  - onehot0(gnt_o);
  - BankLatency >= 1;
  - DataWidth % 8 == 0.

Test Plan:
- NumReq=4, BankLatency=1, MaxWait=0: req_i=4'b1111 held 5 cycles -> gnt_o=0001 every cycle. Narrow ports are never granted. rvalid_o[0] follows one cycle after each grant.
- MaxWait=2: req_i=4'b0011 held -> grant sequence 0,0,1,0,0,1. wait_q goes 0,1,2,0,1,2.
- Narrow round-robin: req_i=4'b1110 held 6 cycles -> grants 1,2,3,1,2,3. Then drop req 2 -> grants skip to 3 then 1.
- BankLatency=3, write 0xDEADBEEF strb=4'hF to addr 5 via port 2, then read addr 5 via port 1 on the next cycle:
  - rvalid_o[2] at t+3 and rvalid_o[1] at t+4;
  - rdata_o[1]=0xDEADBEEF;
  - rdata_o[0,2,3]=0 in that cycle.
- Assert rst_i for 1 cycle while 2 accesses are in flight (BankLatency=3) -> no rvalid_o for them afterwards. wait_q=0, rr_ptr_q=1, and the next narrow grant goes to port 1.
- NumReq=1: random req/we/addr for 1000 cycles -> gnt_o==req_i. rvalid matches req delayed by BankLatency. Read data matches a reference memory model.
